// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair, with cancel and a done pulse.
// Define MD_ACCUM_EN to implement madd/msub (opcodes 110/111); otherwise those opcodes are ignored.
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] v1,
  input  logic [WIDTH-1:0] v2,
  input  logic [2:0]       opt,
  input  logic             start,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MD_ACCUM_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               accept, is_long, finish;
  logic [CNT_W-1:0]   n_cycles;

  always_comb begin
    case (opt)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_long = 1'b1;
`ifdef MD_ACCUM_EN
      OP_MADD, OP_MSUB:                   is_long = 1'b1;
`endif
      default:                            is_long = 1'b0;
    endcase
  end

  assign accept   = start && !cancel && (state_q == S_IDLE);
  assign finish   = (state_q == S_BUSY) && !cancel && (cnt_q == CNT_W'(1));
  assign n_cycles = (opt == OP_DIV || opt == OP_DIVU) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

  // Multiply: sign- or zero-extend to 2*WIDTH so the truncated product is exact.
  logic                 mul_signed;
  logic [2*WIDTH-1:0]   ext_a, ext_b, prod;
  assign mul_signed = (op_q != OP_MULTU);
  assign ext_a      = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign ext_b      = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod       = ext_a * ext_b;

`ifdef MD_ACCUM_EN
  logic [2*WIDTH-1:0] acc;
  assign acc = (op_q == OP_MSUB) ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif

  // Divide on magnitudes; the most-negative/-1 case falls out as the wrapped quotient.
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b, quo_u, rem_u, quo, rem;
  always_comb begin
    a_neg = (op_q == OP_DIV) && a_q[WIDTH-1];
    b_neg = (op_q == OP_DIV) && b_q[WIDTH-1];
    mag_a = a_neg ? -a_q : a_q;
    mag_b = b_neg ? -b_q : b_q;
    quo_u = '0;
    rem_u = '0;
    if (b_q != '0) begin
      quo_u = mag_a / mag_b;
      rem_u = mag_a % mag_b;
    end
    quo = (a_neg ^ b_neg) ? -quo_u : quo_u;
    rem = a_neg ? -rem_u : rem_u;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_long) state_d = S_BUSY;
      S_BUSY:  if (cancel || cnt_q == CNT_W'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (accept) begin
      if (is_long) begin
        op_d  = opt;
        a_d   = v1;
        b_d   = v2;
        cnt_d = n_cycles;
      end else if (opt == OP_MTHI) begin
        hi_d = v1;
      end else if (opt == OP_MTLO) begin
        lo_d = v1;
      end
    end
    if (state_q == S_BUSY) begin
      cnt_d = cancel ? '0 : cnt_q - CNT_W'(1);
      if (finish) begin
        done_d = 1'b1;
        case (op_q)
          OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
          OP_DIV, OP_DIVU: begin
            if (b_q != '0) begin
              lo_d = quo;
              hi_d = rem;
            end
          end
`ifdef MD_ACCUM_EN
          OP_MADD, OP_MSUB:  {hi_d, lo_d} = acc;
`endif
          default: ;
        endcase
      end
    end
  end

  // Outputs
  always_comb begin
    busy = (state_q == S_BUSY);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected HI/LO queued at issue, checked on the done pulse.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [31:0] v1, v2;
  logic [2:0]  opt;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .v1(v1), .v2(v2), .opt(opt), .start(start),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct packed { logic [31:0] hi; logic [31:0] lo; } res_t;
  res_t        sb_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] val);
    opt = op; v1 = val; start = 1'b1;
    step();
    start = 1'b0;
    if (op == 3'b100) exp_hi = val; else exp_lo = val;
    chk("mt_hi", hi, exp_hi);
    chk("mt_lo", lo, exp_lo);
    chk("mt_busy", busy, 0);
    chk("mt_done", done, 0);
  endtask

  // Issues one long operation and returns in its done cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] eh,
                        input logic [31:0] el);
    int   cnt;
    logic early;
    res_t r;
    sb_q.push_back(res_t'{eh, el});
    exp_hi = eh; exp_lo = el;
    opt = op; v1 = a; v2 = b; start = 1'b1;
    step();
    start = 1'b0;
    v1 = $urandom; v2 = $urandom; opt = 3'($urandom);
    cnt = 0; early = 1'b0;
    while (busy && cnt < n + 5) begin
      if (done) early = 1'b1;
      cnt++;
      step();
    end
    chk({tag, "_busycyc"}, cnt, n);
    chk({tag, "_earlydone"}, early, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_sbsize"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      chk({tag, "_hi"}, hi, r.hi);
      chk({tag, "_lo"}, lo, r.lo);
    end
  endtask

  task automatic count_done(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) n++;
      step();
    end
    chk(tag, n, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    logic [63:0] p;
    longint      sp;
    int          sq, sr;

    reset = 1'b0; start = 1'b0; cancel = 1'b0; opt = '0; v1 = '0; v2 = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1'b1;
    step();

    run_op("mult", 3'b000, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", 3'b001, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_op("div", 3'b010, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
    run_op("divu", 3'b011, 32'hFFFFFFF9, 32'd2, 10, 32'h1, 32'h7FFFFFFC);
    step();

    mt(3'b100, 32'h1234);
    mt(3'b101, 32'h5678);
    run_op("div0", 3'b011, 32'd7, 32'd0, 10, 32'h1234, 32'h5678);
    step();

    // start with cancel high in IDLE is ignored
    opt = 3'b100; v1 = 32'hDEAD; start = 1'b1; cancel = 1'b1;
    step();
    start = 1'b0; cancel = 1'b0;
    chk("idlecancel_hi", hi, exp_hi);
    chk("idlecancel_busy", busy, 0);

    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      sp = longint'($signed(a)) * longint'($signed(b));
      p = 64'(sp);
      run_op("rmult", 3'b000, a, b, 5, p[63:32], p[31:0]);
      p = {32'b0, a} * {32'b0, b};
      run_op("rmultu", 3'b001, a, b, 5, p[63:32], p[31:0]);
      b = $urandom_range(1, 1000);
      if (i[0]) b = -b;
      sq = int'(a) / int'(b);
      sr = int'(a) % int'(b);
      run_op("rdiv", 3'b010, a, b, 10, 32'(sr), 32'(sq));
    end
    step();

    // ignored start while busy, then cancel in busy cycle 3
    opt = 3'b000; v1 = 32'd3; v2 = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    chk("cxl_busy1", busy, 1);
    step();
    opt = 3'b101; v1 = 32'hAAAA; start = 1'b1;
    step();
    start = 1'b0;
    chk("cxl_ignlo", lo, exp_lo);
    chk("cxl_busy3", busy, 1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cxl_busy4", busy, 0);
    chk("cxl_done4", done, 0);
    chk("cxl_hi", hi, exp_hi);
    chk("cxl_lo", lo, exp_lo);
    count_done("cxl_nodone", 8);

    // cancel in the final busy cycle wins
    opt = 3'b000; v1 = 32'd3; v2 = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("lastcxl_busy", busy, 1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("lastcxl_busy_after", busy, 0);
    chk("lastcxl_done", done, 0);
    chk("lastcxl_lo", lo, exp_lo);
    count_done("lastcxl_nodone", 4);

    // reset during busy cycle 4 of a div
    opt = 3'b010; v1 = 32'd100; v2 = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_hi = '0; exp_lo = '0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_hi", hi, 0);
    chk("rstmid_lo", lo, 0);
    count_done("rstmid_nodone", 12);

    mt(3'b101, 32'd5);
`ifdef MD_ACCUM_EN
    run_op("madd", 3'b110, 32'd3, 32'd4, 5, 32'h0, 32'h11);
    run_op("msub", 3'b111, 32'd1, 32'h12, 5, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    opt = 3'b110; v1 = 32'd3; v2 = 32'd4; start = 1'b1;
    step();
    start = 1'b0;
    chk("noacc_busy", busy, 0);
    chk("noacc_lo", lo, 32'd5);
    chk("noacc_hi", hi, 32'd0);
    count_done("noacc_nodone", 7);
    chk("noacc_lo_late", lo, 32'd5);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair. It is the next-generation replacement for the fixed 32-bit MD block in the E stage of the five-stage pipeline. It adds configurable datapath width and operation latencies, a cancel input for flushes, a completion pulse, and optional multiply-accumulate. The D-stage hazard logic stalls any HI/LO-class instruction while `busy | start` is high.

## Interface
- `WIDTH`, 32: operand and HI/LO width in bits; must be ≥ 2.
- `MUL_CYCLES`, 5: busy cycles for mult, multu, madd and msub; must be ≥ 1.
- `DIV_CYCLES`, 10: busy cycles for div and divu; must be ≥ 1.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low. `reset == 0` at a rising edge clears all state.
- `v1` in WIDTH: operand rs (multiplicand or dividend; new HI/LO value for mthi/mtlo).
- `v2` in WIDTH: operand rt (multiplier or divisor).
- `opt` in 3: operation select.
  - 000 mult, 001 multu, 010 div, 011 divu.
  - 100 mthi, 101 mtlo.
  - 110 madd, 111 msub (both signed).
- `start` in 1: request; `opt`, `v1` and `v2` are sampled on the edge where it is high.
- `cancel` in 1: abort any in-flight operation (pipeline flush).
- `busy` out 1: an operation is in flight.
- `done` out 1: one-cycle pulse; HI/LO now hold the result of a completed operation.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- **Reset.** `busy=0`, `done=0`, `hi=0`, `lo=0`; cycle counter and operand latches cleared. Reset overrides every other input, including mid-operation.
- **States.** Two states:
  - IDLE → BUSY on an accepted mult, multu, div, divu, madd or msub.
  - BUSY → IDLE when the counter expires or on `cancel`.
- **Acceptance.** `start` is accepted only in IDLE with `cancel == 0`. In BUSY or with `cancel` high, `start` is ignored entirely: no latch, no HI/LO write, no queueing.
- **mthi / mtlo.** Write `v1` to HI or LO at the accepting edge. `busy` is not asserted and `done` is not pulsed.
- **mult / multu.** Produce the 2·WIDTH-bit product, signed or unsigned respectively. HI gets the upper WIDTH bits, LO the lower.
- **madd / msub.** `{HI,LO} ← {HI,LO} ± signed(v1)·signed(v2)`, computed modulo 2^(2·WIDTH). HI:LO is read at completion, not at acceptance.
- **div / divu, results.** LO gets the quotient, HI the remainder. The signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- **div / divu, special cases.**
  - Signed `−2^(WIDTH−1) / −1`: LO = `−2^(WIDTH−1)`, HI = 0.
  - Divisor 0: the full DIV_CYCLES busy period still runs, but HI/LO are left unchanged and `done` still pulses.
- **Cancel.** `cancel` high in BUSY returns to IDLE at that edge: HI/LO unchanged, no `done`. `cancel` in IDLE has no effect.
- **Operand latching.** Operands and opcode are latched at acceptance. Changes on `v1`, `v2` or `opt` during BUSY have no effect.

## Timing
- Define the accepting edge as the end of cycle k.
- `busy` is registered. It is high in cycles k+1 … k+N, where N = MUL_CYCLES or DIV_CYCLES for the accepted operation.
- HI/LO take the new value at the edge ending cycle k+N. They are first visible in cycle k+N+1; in that same cycle `busy=0` and `done=1`, for exactly one cycle.
- A new `start` is accepted in cycle k+N+1, back-to-back with the `done` cycle.
- mthi/mtlo accepted at the end of cycle k are visible on `hi`/`lo` in cycle k+1.
- `cancel` sampled in cycle j of BUSY gives `busy=0` in cycle j+1.
- A `cancel` coinciding with the final busy cycle (cycle k+N) wins: no HI/LO update, no `done`.
- Outputs never change combinationally from inputs.

## Configuration
- `MD_ACCUM_EN` defined: opcodes 110 (madd) and 111 (msub) are implemented as described above.
- `MD_ACCUM_EN` undefined:
  - Opcodes 110 and 111 are no-ops: `start` with them is ignored, `busy` stays 0, HI/LO are unchanged and `done` does not pulse.
  - No accumulate adder is synthesised.

## Test plan
All scenarios use WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10.
- **mult.** `v1=0xFFFFFFFF`, `v2=2`, `start` at cycle 0 → `busy` high in cycles 1–5. In cycle 6: `hi=0xFFFFFFFF`, `lo=0xFFFFFFFE`, `done=1`.
- **multu, then back-to-back div.** multu with the same operands → `hi=0x00000001`, `lo=0xFFFFFFFE`. Then div `v1=0xFFFFFFF9` (−7), `v2=2`, started in the `done` cycle → `busy` high for 10 cycles, then `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
- **Divide by zero.** `hi=0x1234`, `lo=0x5678` preloaded via mthi/mtlo (each visible one cycle after its start). Then divu `7/0` → `busy` high for 10 cycles, `done` pulses, `hi`/`lo` unchanged.
- **Ignored start, then cancel.** Start mult, then assert `start` with mtlo `v1=0xAAAA` in busy cycle 2 → ignored, `lo` unchanged. Assert `cancel` in busy cycle 3 → `busy=0` in cycle 4, no `done`, HI/LO unchanged.
- **Reset mid-operation.** `reset=0` during busy cycle 4 of a div → next cycle `busy=0`, `hi=lo=0`, `done=0`. No `done` pulse afterwards.
- **Accumulate.**
  - With `MD_ACCUM_EN`: `hi=0`, `lo=5`, madd `3×4` → after 5 busy cycles `lo=0x11`, `hi=0`. Then msub `1×0x12` → `hi=lo=0xFFFFFFFF`.
  - Without `MD_ACCUM_EN`: opcode 110 → `busy` stays 0, `lo` stays 5.
